// File: rtl/audio_seq_pkg.sv
// Shared types and constants for the audio sequencing blocks.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package audio_seq_pkg;

  // One note table entry; field order matches the 35-bit write word
  // {freq[34:19], gen_sel[18:16], volume[15:8], dur_ms[7:0]}.
  typedef struct packed {
    logic [15:0] freq;
    logic [2:0]  gen_sel;
    logic [7:0]  volume;
    logic [7:0]  dur_ms;
  } note_entry_t;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_PLAY = 2'd2,
    S_GAP  = 2'd3
  } seq_state_t;

  // 1 ms at 12.5 MHz is 12500 cycles; the prescaler terminal count is one less.
  localparam int          TICK_DIV_1MS = 12499;
  // Phase increment for concert A at the channel's accumulator resolution.
  localparam logic [15:0] FREQ_440HZ   = 16'd4723;

endpackage

// File: rtl/ms_tick_gen.sv
// Millisecond prescaler: counts 0..TICK_DIV and flags the terminal cycle.
// Latency: tick_o is combinational from the count; clr_i takes effect next edge.
// Backpressure: none; free-running unless cleared.
// Ports: clk/rstn (async active-low), clr_i sync clear, tick_o one cycle per period.
module ms_tick_gen #(
  parameter int TICK_DIV = 12499
) (
  input  logic clk,
  input  logic rstn,
  input  logic clr_i,
  output logic tick_o
);

  localparam int CW = (TICK_DIV > 0) ? $clog2(TICK_DIV + 1) : 1;
  localparam logic [CW-1:0] TERM = CW'(TICK_DIV);

  logic [CW-1:0] cnt_q, cnt_d;

  assign tick_o = (cnt_q == TERM);

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (clr_i || tick_o) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/note_sequencer.sv
// Melody sequencer: steps a note table and drives one audio_channel.
// Latency: start sampled -> 1 LOAD cycle -> ch_en_o high on the following edge.
// Backpressure: none; start_i while busy is dropped, stop_i aborts next edge.
// Ports: wr_* table write, len_i/loop_i/start_i/stop_i control, ch_* channel
// drive, busy_o/note_idx_o/done_o status.
// Build option: define NOTE_SEQ_ENVELOPE_EN for a linear volume attack.
module note_sequencer
  import audio_seq_pkg::*;
#(
  parameter int DEPTH    = 16,
  parameter int TICK_DIV = TICK_DIV_1MS,
  parameter int GAP_MS   = 1,
  parameter int ENV_STEP = 8
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     wr_en_i,
  input  logic [$clog2(DEPTH)-1:0] wr_addr_i,
  input  logic [34:0]              wr_data_i,
  input  logic [$clog2(DEPTH):0]   len_i,
  input  logic                     loop_i,
  input  logic                     start_i,
  input  logic                     stop_i,
  output logic                     ch_en_o,
  output logic [2:0]               ch_gen_sel_o,
  output logic [15:0]              ch_freq_o,
  output logic [7:0]               ch_volume_o,
  output logic                     busy_o,
  output logic [$clog2(DEPTH)-1:0] note_idx_o,
  output logic                     done_o
);

  localparam int AW = $clog2(DEPTH);

  note_entry_t table_mem [DEPTH];
  note_entry_t rd_entry_q;

  seq_state_t  state_q, state_d;
  logic [AW-1:0] idx_q, idx_d;
  logic [AW:0]   len_q, len_d;
  logic          loop_q, loop_d;
  logic [7:0]    dur_q, dur_d;
  logic          ch_en_q, ch_en_d;
  logic [2:0]    gen_sel_q, gen_sel_d;
  logic [15:0]   freq_q, freq_d;
  logic [7:0]    volume_q, volume_d;
  logic          done_q, done_d;
  logic          advance;
  logic [AW:0]   next_idx_ext;
  logic          tick;
  logic          tick_clr;

`ifdef NOTE_SEQ_ENVELOPE_EN
  logic [7:0] target_vol_q, target_vol_d;
  logic [8:0] env_sum;
`else
  logic [7:0] unused_env_step;
  assign unused_env_step = 8'(ENV_STEP);
`endif

  // Prescaler restarts on every state change so each PLAY/GAP ms is whole.
  assign tick_clr = (state_d != state_q) || (state_q == S_IDLE) || (state_q == S_LOAD);

  ms_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
    .clk    (clk),
    .rstn   (rstn),
    .clr_i  (tick_clr),
    .tick_o (tick)
  );

  // Read address is the next index so the entry is already registered
  // during the single LOAD cycle.
  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      table_mem[wr_addr_i] <= note_entry_t'(wr_data_i);
    end
    rd_entry_q <= table_mem[idx_d];
  end

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    len_d        = len_q;
    loop_d       = loop_q;
    dur_d        = dur_q;
    ch_en_d      = ch_en_q;
    gen_sel_d    = gen_sel_q;
    freq_d       = freq_q;
    volume_d     = volume_q;
    done_d       = 1'b0;
    advance      = 1'b0;
    next_idx_ext = {1'b0, idx_q} + 1'b1;
`ifdef NOTE_SEQ_ENVELOPE_EN
    target_vol_d = target_vol_q;
    env_sum      = {1'b0, volume_q} + 9'(ENV_STEP);
`endif

    case (state_q)
      S_IDLE: begin
        ch_en_d = 1'b0;
        if (start_i && !stop_i && (len_i != '0)) begin
          len_d   = len_i;
          loop_d  = loop_i;
          idx_d   = '0;
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        if (rd_entry_q.dur_ms == 8'd0) begin
          advance = 1'b1;
        end else begin
          state_d   = S_PLAY;
          ch_en_d   = 1'b1;
          freq_d    = rd_entry_q.freq;
          gen_sel_d = rd_entry_q.gen_sel;
          dur_d     = rd_entry_q.dur_ms;
`ifdef NOTE_SEQ_ENVELOPE_EN
          target_vol_d = rd_entry_q.volume;
          volume_d     = (rd_entry_q.volume < 8'(ENV_STEP)) ? rd_entry_q.volume : 8'(ENV_STEP);
`else
          volume_d     = rd_entry_q.volume;
`endif
        end
      end
      S_PLAY: begin
        if (tick) begin
          if (dur_q == 8'd1) begin
            ch_en_d = 1'b0;
            if (GAP_MS == 0) begin
              advance = 1'b1;
            end else begin
              state_d = S_GAP;
              dur_d   = 8'(GAP_MS);
            end
          end else begin
            dur_d = dur_q - 1'b1;
`ifdef NOTE_SEQ_ENVELOPE_EN
            volume_d = (env_sum > {1'b0, target_vol_q}) ? target_vol_q : env_sum[7:0];
`endif
          end
        end
      end
      S_GAP: begin
        if (tick) begin
          if (dur_q == 8'd1) begin
            advance = 1'b1;
          end else begin
            dur_d = dur_q - 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (advance) begin
      if (next_idx_ext < len_q) begin
        idx_d   = AW'(next_idx_ext);
        state_d = S_LOAD;
      end else if (loop_q) begin
        idx_d   = '0;
        state_d = S_LOAD;
      end else begin
        state_d = S_IDLE;
        done_d  = 1'b1;
      end
    end

    // Abort wins over everything, including a natural end on the same edge.
    if (stop_i && (state_q != S_IDLE)) begin
      state_d = S_IDLE;
      ch_en_d = 1'b0;
      done_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= S_IDLE;
      idx_q     <= '0;
      len_q     <= '0;
      loop_q    <= 1'b0;
      dur_q     <= '0;
      ch_en_q   <= 1'b0;
      gen_sel_q <= '0;
      freq_q    <= '0;
      volume_q  <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      len_q     <= len_d;
      loop_q    <= loop_d;
      dur_q     <= dur_d;
      ch_en_q   <= ch_en_d;
      gen_sel_q <= gen_sel_d;
      freq_q    <= freq_d;
      volume_q  <= volume_d;
      done_q    <= done_d;
    end
  end

`ifdef NOTE_SEQ_ENVELOPE_EN
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      target_vol_q <= '0;
    end else begin
      target_vol_q <= target_vol_d;
    end
  end
`endif

  assign ch_en_o      = ch_en_q;
  assign ch_gen_sel_o = gen_sel_q;
  assign ch_freq_o    = freq_q;
  assign ch_volume_o  = volume_q;
  assign busy_o       = (state_q != S_IDLE);
  assign note_idx_o   = idx_q;
  assign done_o       = done_q;

endmodule
